// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types for the signal-routing mux select controller.
// Holds the scan FSM state encoding and default widths.
package mux_scan_ctrl_pkg;

  localparam int SEL_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DWELL  = 2'd3
  } state_e;

endpackage

// File: rtl/mux_next_ch.sv
// Wrap-around priority encoder: lowest set mask bit at index >= ptr.
// Ports: mask, ptr in; idx, wrapped (search restarted at 0), none (mask empty) out.
module mux_next_ch
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [2**SEL_W-1:0] mask,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    idx,
  output logic                wrapped,
  output logic                none
);

  localparam int N = 2**SEL_W;

  logic [N-1:0]     hi;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;

  always_comb begin
    hi      = mask & ({N{1'b1}} << ptr);
    hi_idx  = '0;
    lo_idx  = '0;
    none    = (mask == '0);
    wrapped = 1'b0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi[i])   hi_idx = SEL_W'(i);
      if (mask[i]) lo_idx = SEL_W'(i);
    end
    if (hi != '0) begin
      idx = hi_idx;
    end else begin
      idx     = lo_idx;
      wrapped = !none;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select controller for the 32:1 routing mux: manual or masked auto scan.
// Ports: clk, rst, auto_en, man_sel, ch_mask, settle, dwell, start, stop in;
//        sel, blank, sample_stb, cur_ch, busy, frame_done out (all registered).
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                auto_en,
  input  logic [SEL_W-1:0]    man_sel,
  input  logic [2**SEL_W-1:0] ch_mask,
  input  logic [CNT_W-1:0]    settle,
  input  logic [CNT_W-1:0]    dwell,
  input  logic                start,
  input  logic                stop,
  output logic [SEL_W-1:0]    sel,
  output logic                blank,
  output logic                sample_stb,
  output logic [SEL_W-1:0]    cur_ch,
  output logic                busy,
  output logic                frame_done
);

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [SEL_W-1:0] ptr_q, ptr_n;
  logic             wrap_q, wrap_n;
  logic [SEL_W-1:0] sel_n, cur_n;
  logic             blank_n, stb_n, busy_n, fd_n;

  logic [SEL_W-1:0] nx_idx;
  logic             nx_wrap, nx_none;
  logic [CNT_W-1:0] dwell1;
  logic             abort;

  mux_next_ch #(.SEL_W(SEL_W)) u_next (
    .mask    (ch_mask),
    .ptr     (ptr_q),
    .idx     (nx_idx),
    .wrapped (nx_wrap),
    .none    (nx_none)
  );

  assign dwell1 = (dwell == '0) ? CNT_W'(1) : dwell;
  assign abort  = stop | ~auto_en;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ptr_n   = ptr_q;
    wrap_n  = wrap_q;
    sel_n   = sel;
    cur_n   = cur_ch;
    blank_n = blank;
    stb_n   = 1'b0;
    fd_n    = 1'b0;
    if (state_q != ST_IDLE && abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      wrap_n  = 1'b0;
      blank_n = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sel_n = man_sel;
          if (man_sel != sel) begin
            cnt_n   = settle;
            blank_n = (settle != '0);
          end else if (cnt_q != '0) begin
            cnt_n   = cnt_q - CNT_W'(1);
            blank_n = (cnt_q > CNT_W'(1));
          end else begin
            blank_n = 1'b0;
          end
          if (start && !stop && auto_en && ch_mask != '0) begin
            state_n = ST_SEARCH;
            ptr_n   = '0;
            wrap_n  = 1'b0;
          end
        end
        ST_SEARCH: begin
          wrap_n = 1'b0;
          if (nx_none) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            blank_n = 1'b0;
          end else begin
            sel_n = nx_idx;
            cur_n = nx_idx;
            // wrap_q covers a pass that ended on the top channel
            fd_n  = nx_wrap | wrap_q;
            if (settle != '0) begin
              state_n = ST_SETTLE;
              cnt_n   = settle;
              blank_n = 1'b1;
            end else begin
              state_n = ST_DWELL;
              cnt_n   = dwell1;
              blank_n = 1'b0;
              stb_n   = (dwell1 == CNT_W'(1));
            end
          end
        end
        ST_SETTLE: begin
          blank_n = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_n = ST_DWELL;
            cnt_n   = dwell1;
            blank_n = 1'b0;
            stb_n   = (dwell1 == CNT_W'(1));
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        ST_DWELL: begin
          blank_n = 1'b0;
          if (cnt_q <= CNT_W'(1)) begin
            state_n = ST_SEARCH;
            cnt_n   = '0;
            ptr_n   = cur_ch + SEL_W'(1);
            wrap_n  = &cur_ch;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
            // strobe lands on the cycle the count reads 1
            stb_n = (cnt_q == CNT_W'(2));
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      wrap_q     <= 1'b0;
      sel        <= '0;
      blank      <= 1'b0;
      sample_stb <= 1'b0;
      cur_ch     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      ptr_q      <= ptr_n;
      wrap_q     <= wrap_n;
      sel        <= sel_n;
      blank      <= blank_n;
      sample_stb <= stb_n;
      cur_ch     <= cur_n;
      busy       <= busy_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl.
// Steps through manual, auto, edge, abort, mask and reset scenarios.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto_en;
  logic [4:0]  man_sel;
  logic [31:0] ch_mask;
  logic [15:0] settle;
  logic [15:0] dwell;
  logic        start;
  logic        stop;
  logic [4:0]  sel;
  logic        blank;
  logic        sample_stb;
  logic [4:0]  cur_ch;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  mux_scan_ctrl #(.SEL_W(5), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .auto_en    (auto_en),
    .man_sel    (man_sel),
    .ch_mask    (ch_mask),
    .settle     (settle),
    .dwell      (dwell),
    .start      (start),
    .stop       (stop),
    .sel        (sel),
    .blank      (blank),
    .sample_stb (sample_stb),
    .cur_ch     (cur_ch),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enter from a SEARCH cycle; leave in the following SEARCH cycle.
  task automatic chan(input int ch, input int fd, input int ns, input int nd);
    int bad;
    bad = 0;
    step(1);
    chk("sel", 32'(sel), 32'(ch));
    chk("cur_ch", 32'(cur_ch), 32'(ch));
    chk("frame_done", 32'(frame_done), 32'(fd));
    for (int i = 0; i < ns + nd; i++) begin
      if (i > 0) begin
        step(1);
        if (frame_done !== 1'b0) bad++;
      end
      if (blank !== 1'(i < ns)) bad++;
      if (sample_stb !== 1'(i == ns + nd - 1)) bad++;
      if (busy !== 1'b1 || sel !== 5'(ch)) bad++;
    end
    step(1);
    if (sample_stb !== 1'b0 || blank !== 1'b0 || busy !== 1'b1) bad++;
    chk("window", 32'(bad), 32'd0);
  endtask

  initial begin
    int nb;
    int ns;
    rst     = 1'b1;
    auto_en = 1'b0;
    man_sel = 5'd0;
    ch_mask = 32'h0;
    settle  = 16'd3;
    dwell   = 16'd0;
    start   = 1'b0;
    stop    = 1'b0;
    step(2);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stb", 32'(sample_stb), 32'd0);
    rst = 1'b0;
    step(1);

    // manual switch 0 -> 7, settle 3
    man_sel = 5'd7;
    nb = 0;
    step(1);
    chk("man_sel", 32'(sel), 32'd7);
    nb += 32'(blank);
    repeat (5) begin
      step(1);
      nb += 32'(blank);
    end
    chk("man_blank_len", 32'(nb), 32'd3);
    chk("man_busy", 32'(busy), 32'd0);

    // auto scan 0x25
    auto_en = 1'b1;
    ch_mask = 32'h0000_0025;
    settle  = 16'd2;
    dwell   = 16'd4;
    start   = 1'b1;
    step(1);
    start = 1'b0;
    chk("auto_busy", 32'(busy), 32'd1);
    chan(0, 0, 2, 4);
    chan(2, 0, 2, 4);
    chan(5, 0, 2, 4);
    chan(0, 1, 2, 4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);

    // zero settle, zero dwell, channels 0 and 31
    settle  = 16'd0;
    dwell   = 16'd0;
    ch_mask = 32'h8000_0001;
    step(1);
    chk("edge_idle_sel", 32'(sel), 32'd7);
    chk("edge_idle_blank", 32'(blank), 32'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chan(0, 0, 0, 1);
    chan(31, 0, 0, 1);
    chan(0, 1, 0, 1);
    chan(31, 0, 0, 1);
    chan(0, 1, 0, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    // stop during SETTLE on channel 2
    settle  = 16'd3;
    dwell   = 16'd2;
    ch_mask = 32'h0000_0004;
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    chk("ab_sel", 32'(sel), 32'd2);
    chk("ab_blank", 32'(blank), 32'd1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_stb", 32'(sample_stb), 32'd0);
    step(1);
    chk("ab_man_sel", 32'(sel), 32'd7);
    ns = 0;
    repeat (8) begin
      step(1);
      ns += 32'(sample_stb) + 32'(busy);
    end
    chk("ab_quiet", 32'(ns), 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    step(1);
    chk("startstop_busy2", 32'(busy), 32'd0);

    // mask cleared mid-DWELL
    settle = 16'd1;
    dwell  = 16'd3;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    chk("mk_sel", 32'(sel), 32'd2);
    step(1);
    ch_mask = 32'h0;
    step(1);
    step(1);
    chk("mk_stb", 32'(sample_stb), 32'd1);
    chk("mk_cur", 32'(cur_ch), 32'd2);
    step(1);
    chk("mk_search_busy", 32'(busy), 32'd1);
    step(1);
    chk("mk_idle_busy", 32'(busy), 32'd0);
    chk("mk_fd", 32'(frame_done), 32'd0);
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("mk0_busy", 32'(busy), 32'd0);
    step(1);
    chk("mk0_busy2", 32'(busy), 32'd0);

    // reset mid-DWELL, then restart
    ch_mask = 32'h0000_0025;
    settle  = 16'd2;
    dwell   = 16'd4;
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chan(0, 0, 2, 4);
    step(4);
    chk("pre_rst_sel", 32'(sel), 32'd2);
    rst     = 1'b1;
    man_sel = 5'd0;
    step(1);
    rst = 1'b0;
    chk("mr_sel", 32'(sel), 32'd0);
    chk("mr_blank", 32'(blank), 32'd0);
    chk("mr_stb", 32'(sample_stb), 32'd0);
    chk("mr_cur", 32'(cur_ch), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_fd", 32'(frame_done), 32'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chan(0, 0, 2, 4);
    chan(2, 0, 2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
